// File: rtl/eth_10g_axil_regs.sv
// AXI4-Lite register bank for the eth_10g control port: four RW config registers,
// a live status word and a clear-on-read received-frame counter.
module eth_10g_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [31:0]                       reg0_out,
    output logic [31:0]                       reg1_out,
    output logic [31:0]                       reg2_out,
    output logic [31:0]                       reg3_out,
    input  logic [31:0]                       status_in,
    input  logic                              frame_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] cfg_r [4];
    logic        aw_held_r, w_held_r;
    logic [2:0]  aw_idx_r;
    logic [31:0] w_data_r;
    logic [3:0]  w_strb_r;
    logic        awready_r, wready_r, arready_r;
    logic        bvalid_r, rvalid_r;
    logic [1:0]  bresp_r, rresp_r;
    logic [31:0] rdata_r, frmcnt_r;

    logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic        aw_held_n_s, w_held_n_s, bvalid_n_s, rvalid_n_s;
    logic [1:0]  bresp_n_s, rresp_n_s;
    logic [31:0] rdata_n_s, frmcnt_n_s;
    logic        unused_s;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Handshakes, write commit and next-state of every control/response register.
    always_comb begin
        aw_hs_s  = S_AXI_AWVALID & awready_r;
        w_hs_s   = S_AXI_WVALID & wready_r;
        ar_hs_s  = S_AXI_ARVALID & arready_r;
        commit_s = aw_held_r & w_held_r & ~bvalid_r;

        aw_held_n_s = aw_held_r;
        w_held_n_s  = w_held_r;
        bvalid_n_s  = bvalid_r;
        bresp_n_s   = bresp_r;
        rvalid_n_s  = rvalid_r;
        rresp_n_s   = rresp_r;
        rdata_n_s   = rdata_r;
        frmcnt_n_s  = frmcnt_r;

        if (commit_s) begin
            aw_held_n_s = 1'b0;
            w_held_n_s  = 1'b0;
            bvalid_n_s  = 1'b1;
            bresp_n_s   = aw_idx_r[2] ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_hs_s) aw_held_n_s = 1'b1; else aw_held_n_s = aw_held_r;
            if (w_hs_s)  w_held_n_s  = 1'b1; else w_held_n_s  = w_held_r;
            if (bvalid_r && S_AXI_BREADY) bvalid_n_s = 1'b0; else bvalid_n_s = bvalid_r;
        end

        if (ar_hs_s) begin
            rvalid_n_s = 1'b1;
            rresp_n_s  = RESP_OKAY;
            case (S_AXI_ARADDR[4:2])
                3'd0:    rdata_n_s = cfg_r[0];
                3'd1:    rdata_n_s = cfg_r[1];
                3'd2:    rdata_n_s = cfg_r[2];
                3'd3:    rdata_n_s = cfg_r[3];
                3'd4:    rdata_n_s = status_in;
                3'd5:    rdata_n_s = frmcnt_r;
                default: begin
                    rdata_n_s = 32'd0;
                    rresp_n_s = RESP_SLVERR;
                end
            endcase
        end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_n_s = 1'b0;
        end else begin
            rvalid_n_s = rvalid_r;
        end

        // A pulse landing on the clearing edge is the first frame of the new count.
        if (ar_hs_s && (S_AXI_ARADDR[4:2] == 3'd5)) begin
            frmcnt_n_s = frame_pulse ? 32'd1 : 32'd0;
        end else if (frame_pulse) begin
            frmcnt_n_s = frmcnt_r + 32'd1;
        end else begin
            frmcnt_n_s = frmcnt_r;
        end
    end

    // State registers; READYs are derived from next-state so they stay registered.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) cfg_r[i] <= 32'd0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_idx_r  <= 3'd0;
            w_data_r  <= 32'd0;
            w_strb_r  <= 4'd0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            arready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            rvalid_r  <= 1'b0;
            rresp_r   <= 2'b00;
            rdata_r   <= 32'd0;
            frmcnt_r  <= 32'd0;
        end else begin
            if (aw_hs_s) aw_idx_r <= S_AXI_AWADDR[4:2];
            if (w_hs_s) begin
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end
            if (commit_s && !aw_idx_r[2]) begin
                cfg_r[aw_idx_r[1:0]] <= merge_bytes(cfg_r[aw_idx_r[1:0]], w_data_r, w_strb_r);
            end
            aw_held_r <= aw_held_n_s;
            w_held_r  <= w_held_n_s;
            awready_r <= ~aw_held_n_s & ~bvalid_n_s;
            wready_r  <= ~w_held_n_s & ~bvalid_n_s;
            arready_r <= ~rvalid_n_s;
            bvalid_r  <= bvalid_n_s;
            bresp_r   <= bresp_n_s;
            rvalid_r  <= rvalid_n_s;
            rresp_r   <= rresp_n_s;
            rdata_r   <= rdata_n_s;
            frmcnt_r  <= frmcnt_n_s;
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign reg0_out      = cfg_r[0];
    assign reg1_out      = cfg_r[1];
    assign reg2_out      = cfg_r[2];
    assign reg3_out      = cfg_r[3];

endmodule

// File: tb/tb_eth_10g_axil_regs.sv
// Directed self-checking bench for eth_10g_axil_regs; inputs driven and outputs
// sampled on the falling edge, handshakes complete on the rising edge.
module tb_eth_10g_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
    logic [31:0] status_in;
    logic        frame_pulse;

    int checks_r   = 0;
    int failures_r = 0;

    eth_10g_axil_regs dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out), .reg3_out(reg3_out),
        .status_in(status_in), .frame_pulse(frame_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int  n;
        bit  aw_go, w_go;
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data;  S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 50) begin
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            n++;
            if (aw_go) S_AXI_AWVALID = 1'b0;
            if (w_go)  S_AXI_WVALID  = 1'b0;
        end
        check_eq("wr_addr_data_accepted", {31'd0, n < 50}, 32'd1);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("wr_bvalid_seen", {31'd0, S_AXI_BVALID}, 32'd1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, input bit pulse,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("rd_ar_accepted", {31'd0, S_AXI_ARREADY}, 32'd1);
        frame_pulse = pulse;
        @(negedge ACLK);
        frame_pulse = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check_eq("rd_rvalid_after_ar", {31'd0, S_AXI_RVALID}, 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    logic [1:0]  resp_v;
    logic [31:0] data_v;
    logic [31:0] exp_regs [4];

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWADDR = 5'd0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 5'd0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        status_in = 32'hDEAD_BEEF;
        frame_pulse = 1'b0;
        exp_regs[0] = 32'h1; exp_regs[1] = 32'h2; exp_regs[2] = 32'h3; exp_regs[3] = 32'h4;

        repeat (3) @(negedge ACLK);
        check_eq("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        check_eq("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        check_eq("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
        check_eq("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
        check_eq("rst_rdata",   S_AXI_RDATA, 32'd0);
        check_eq("rst_reg0",    reg0_out, 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_eq("post_rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        check_eq("post_rst_wready",  {31'd0, S_AXI_WREADY},  32'd1);
        check_eq("post_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Basic write/readback of the four config registers.
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), exp_regs[i], 4'hF, resp_v);
            check_eq("wr_cfg_bresp", {30'd0, resp_v}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), 1'b0, data_v, resp_v);
            check_eq("rd_cfg_data", data_v, exp_regs[i]);
            check_eq("rd_cfg_rresp", {30'd0, resp_v}, 32'd0);
        end
        check_eq("reg0_out", reg0_out, 32'h1);
        check_eq("reg1_out", reg1_out, 32'h2);
        check_eq("reg2_out", reg2_out, 32'h3);
        check_eq("reg3_out", reg3_out, 32'h4);

        // Byte strobes.
        axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, resp_v);
        axi_write(5'h04, 32'h1234_5678, 4'b0101, resp_v);
        axi_read(5'h04, 1'b0, data_v, resp_v);
        check_eq("strb_readback", data_v, 32'hFF34_FF78);
        check_eq("strb_reg1_out", reg1_out, 32'hFF34_FF78);

        // W three cycles ahead of AW, BREADY held low for 5 cycles.
        @(negedge ACLK);
        S_AXI_WDATA = 32'hA5A5_0002; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        check_eq("wfirst_wready", {31'd0, S_AXI_WREADY}, 32'd1);
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        check_eq("wfirst_wready_held", {31'd0, S_AXI_WREADY}, 32'd0);
        check_eq("wfirst_no_commit", reg2_out, 32'h3);
        @(negedge ACLK);
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        check_eq("wfirst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        check_eq("wfirst_bvalid_early", {31'd0, S_AXI_BVALID}, 32'd0);
        @(negedge ACLK);
        for (int i = 0; i < 5; i++) begin
            check_eq("bstall_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
            check_eq("bstall_ready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
            @(negedge ACLK);
        end
        check_eq("bstall_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        check_eq("bstall_reg2", reg2_out, 32'hA5A5_0002);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check_eq("bstall_bvalid_drop", {31'd0, S_AXI_BVALID}, 32'd0);
        check_eq("bstall_ready_back", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);

        // Unmapped / read-only targets.
        axi_write(5'h18, 32'hCAFE_F00D, 4'hF, resp_v);
        check_eq("wr_0x18_slverr", {30'd0, resp_v}, 32'd2);
        axi_read(5'h1C, 1'b0, data_v, resp_v);
        check_eq("rd_0x1c_slverr", {30'd0, resp_v}, 32'd2);
        check_eq("rd_0x1c_data", data_v, 32'd0);
        axi_write(5'h10, 32'h1111_1111, 4'hF, resp_v);
        check_eq("wr_0x10_slverr", {30'd0, resp_v}, 32'd2);
        check_eq("slverr_reg0", reg0_out, 32'h1);
        check_eq("slverr_reg1", reg1_out, 32'hFF34_FF78);
        check_eq("slverr_reg2", reg2_out, 32'hA5A5_0002);
        check_eq("slverr_reg3", reg3_out, 32'h4);
        axi_read(5'h10, 1'b0, data_v, resp_v);
        check_eq("rd_status", data_v, 32'hDEAD_BEEF);
        check_eq("rd_status_rresp", {30'd0, resp_v}, 32'd0);

        // Frame counter with a pulse on the clearing edge.
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            frame_pulse = 1'b1;
            @(negedge ACLK);
            frame_pulse = 1'b0;
        end
        axi_read(5'h14, 1'b1, data_v, resp_v);
        check_eq("frmcnt_first", data_v, 32'd5);
        axi_read(5'h14, 1'b0, data_v, resp_v);
        check_eq("frmcnt_second", data_v, 32'd1);
        axi_read(5'h14, 1'b0, data_v, resp_v);
        check_eq("frmcnt_cleared", data_v, 32'd0);

        // Reset between AW and W handshakes.
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        ARESETN = 1'b0;
        @(negedge ACLK);
        check_eq("midrst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        S_AXI_WDATA = 32'h7777_7777; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        check_eq("midrst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        check_eq("midrst_regs", reg0_out | reg1_out | reg2_out | reg3_out, 32'd0);
        // The lone W is still held; an AW completes it.
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        check_eq("midrst_new_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check_eq("midrst_new_reg3", reg3_out, 32'h7777_7777);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        axi_write(5'h00, 32'h0BAD_CAFE, 4'hF, resp_v);
        check_eq("midrst_write_bresp", {30'd0, resp_v}, 32'd0);
        check_eq("midrst_write_reg0", reg0_out, 32'h0BAD_CAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
